// File: rtl/cam_ctrl_pkg.sv
// Shared types and helpers for the CAM fill controller: FSM state encoding,
// reset values and the lowest-free-slot search used for victim selection.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM,
        FILL,
        FLUSH,
        RESP
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

    // The search works on a fixed-width vector; instances zero-extend their
    // valid vector and pass their real entry count, so WORDS must not exceed this.
    localparam int MAX_WORDS = 64;
    localparam int MAX_IDX_W = $clog2(MAX_WORDS);

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } free_t;

    function automatic free_t first_free(input logic [MAX_WORDS-1:0] valid, input int words);
        free_t r;
        r = '0;
        // Scan downward so the last hit kept is the lowest free index.
        for (int i = MAX_WORDS - 1; i >= 0; i--) begin
            if (i < words && !valid[i]) begin
                r.found = 1'b1;
                r.idx   = MAX_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cam_victim_sel.sv
// Shadow occupancy tracker: valid vector, round-robin pointer for full-CAM
// replacement, current victim choice and registered full flag.
module cam_victim_sel
    import cam_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               i_fill_en,
    input  logic [ADDR_LEFT:0] i_fill_idx,
    input  logic               i_clear_all,
    output logic [ADDR_LEFT:0] o_victim,
    output logic               o_full
);

    localparam int                 AW        = ADDR_LEFT + 1;
    localparam logic [ADDR_LEFT:0] LAST_SLOT = AW'(WORDS - 1);

    logic [WORDS-1:0]   r_valid;
    logic [WORDS-1:0]   w_valid_nxt;
    logic [ADDR_LEFT:0] r_rr;
    logic               r_full;
    free_t              w_free;
    logic               w_all_set;

    always_comb begin
        w_free    = first_free(MAX_WORDS'(r_valid), WORDS);
        w_all_set = &r_valid;
        o_victim  = w_free.found ? AW'(w_free.idx) : r_rr;

        w_valid_nxt = r_valid;
        if (i_clear_all) begin
            w_valid_nxt = '0;
        end else if (i_fill_en) begin
            w_valid_nxt[i_fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_valid <= '0;
            r_rr    <= '0;
            r_full  <= RST_BIT;
        end else begin
            r_valid <= w_valid_nxt;
            r_full  <= &w_valid_nxt;
            if (i_clear_all) begin
                r_rr <= '0;
            end else if (i_fill_en && w_all_set) begin
                // Only a replacement into a full CAM consumes the pointer.
                r_rr <= (r_rr == LAST_SLOT) ? '0 : r_rr + 1'b1;
            end
        end
    end

    assign o_full = r_full;

endmodule

// File: rtl/cam_fill_ctrl.sv
// CAM front-end: lookup over valid/ready, miss fill from backing memory over
// req/ack into a victim slot, and a flush-all that clears every entry.
module cam_fill_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int TAG_SZ    = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_flush,
    input  logic [TAG_SZ-1:0]  req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    output logic [BITS-1:0]    resp_data,
    output logic               full,
    output logic               cam_read,
    output logic [TAG_SZ-1:0]  cam_check_tag,
    input  logic               cam_found_it,
    input  logic [BITS-1:0]    cam_data,
    output logic               cam_write_,
    output logic [ADDR_LEFT:0] cam_w_addr,
    output logic [BITS-1:0]    cam_wdata,
    output logic [TAG_SZ-1:0]  cam_new_tag,
    output logic               cam_new_valid,
    output logic               mem_req,
    output logic [TAG_SZ-1:0]  mem_tag,
    input  logic               mem_ack,
    input  logic [BITS-1:0]    mem_rdata
);

    localparam int                 AW        = ADDR_LEFT + 1;
    localparam logic [ADDR_LEFT:0] LAST_SLOT = AW'(WORDS - 1);

    // Handshakes: a request transfers on a clock edge with req_valid && req_ready;
    // a response transfers with resp_valid && resp_ready and resp_valid/data hold
    // until then; mem_req holds until a one-cycle mem_ack carries mem_rdata.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [TAG_SZ-1:0]  r_tag;
    logic [BITS-1:0]    r_data;
    logic               r_hit;
    logic [ADDR_LEFT:0] r_flush_cnt;
    logic [ADDR_LEFT:0] r_victim;
    logic [ADDR_LEFT:0] w_victim;
    logic               w_fill_en;
    logic               w_clear_all;
    logic               w_flush_last;

    cam_victim_sel #(
        .WORDS     (WORDS),
        .ADDR_LEFT (ADDR_LEFT)
    ) u_victim_sel (
        .clk         (clk),
        .rst_        (rst_),
        .i_fill_en   (w_fill_en),
        .i_fill_idx  (r_victim),
        .i_clear_all (w_clear_all),
        .o_victim    (w_victim),
        .o_full      (full)
    );

    assign w_flush_last  = (r_flush_cnt == LAST_SLOT);
    assign cam_check_tag = r_tag;
    assign mem_tag       = r_tag;
    assign resp_hit      = r_hit;
    assign resp_data     = r_data;

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        cam_read      = 1'b0;
        cam_write_    = 1'b1;
        cam_w_addr    = '0;
        cam_wdata     = '0;
        cam_new_tag   = '0;
        cam_new_valid = 1'b0;
        mem_req       = 1'b0;
        w_fill_en     = 1'b0;
        w_clear_all   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = req_flush ? FLUSH : LOOKUP;
                end
            end
            LOOKUP: begin
                cam_read    = 1'b1;
                w_state_nxt = cam_found_it ? RESP : MEM;
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                cam_write_    = 1'b0;
                cam_w_addr    = r_victim;
                cam_wdata     = r_data;
                cam_new_tag   = r_tag;
                cam_new_valid = 1'b1;
                w_fill_en     = 1'b1;
                w_state_nxt   = RESP;
            end
            FLUSH: begin
                cam_write_ = 1'b0;
                cam_w_addr = r_flush_cnt;
                if (w_flush_last) begin
                    w_clear_all = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= RST_STATE;
            r_tag       <= '0;
            r_data      <= '0;
            r_hit       <= RST_BIT;
            r_flush_cnt <= '0;
            r_victim    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_tag <= req_tag;
                    end
                end
                LOOKUP: begin
                    if (cam_found_it) begin
                        r_data <= cam_data;
                        r_hit  <= 1'b1;
                    end
                end
                MEM: begin
                    // Victim is frozen here so FILL writes a stable slot.
                    if (mem_ack) begin
                        r_data   <= mem_rdata;
                        r_victim <= w_victim;
                    end
                end
                FILL: r_hit <= 1'b0;
                FLUSH: begin
                    if (w_flush_last) begin
                        r_flush_cnt <= '0;
                        r_data      <= '0;
                        r_hit       <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Randomized bench for cam_fill_ctrl: behavioural CAM and memory around the
// DUT, and a slot-level cache model producing expected responses and writes.
module tb_cam_fill_ctrl;

    localparam int WORDS  = 8;
    localparam int BITS   = 8;
    localparam int TAG_SZ = 8;
    localparam int AL     = $clog2(WORDS) - 1;

    logic              clk = 1'b0;
    logic              rst_;
    logic              req_valid, req_ready, req_flush;
    logic [TAG_SZ-1:0] req_tag;
    logic              resp_valid, resp_ready, resp_hit;
    logic [BITS-1:0]   resp_data;
    logic              full;
    logic              cam_read;
    logic [TAG_SZ-1:0] cam_check_tag;
    logic              cam_found_it;
    logic [BITS-1:0]   cam_data;
    logic              cam_write_;
    logic [AL:0]       cam_w_addr;
    logic [BITS-1:0]   cam_wdata;
    logic [TAG_SZ-1:0] cam_new_tag;
    logic              cam_new_valid;
    logic              mem_req;
    logic [TAG_SZ-1:0] mem_tag;
    logic              mem_ack;
    logic [BITS-1:0]   mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_fill_ctrl #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready), .req_flush(req_flush), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_data(resp_data),
        .full(full), .cam_read(cam_read), .cam_check_tag(cam_check_tag),
        .cam_found_it(cam_found_it), .cam_data(cam_data), .cam_write_(cam_write_),
        .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag),
        .cam_new_valid(cam_new_valid), .mem_req(mem_req), .mem_tag(mem_tag),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Behavioural CAM the controller drives.
    logic [TAG_SZ-1:0] b_tag [WORDS];
    logic [BITS-1:0]   b_dat [WORDS];
    logic              b_v   [WORDS];

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            b_tag[i] = '0;
            b_dat[i] = '0;
            b_v[i]   = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!cam_write_) begin
            b_tag[cam_w_addr] <= cam_new_tag;
            b_dat[cam_w_addr] <= cam_wdata;
            b_v[cam_w_addr]   <= cam_new_valid;
        end
    end

    always_comb begin
        cam_found_it = 1'b0;
        cam_data     = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (b_v[i] && b_tag[i] == cam_check_tag) begin
                cam_found_it = 1'b1;
                cam_data     = b_dat[i];
            end
        end
    end

    // Reference: which tag/data each slot holds, plus replacement pointer.
    logic [TAG_SZ-1:0] m_tag [WORDS];
    logic [BITS-1:0]   m_dat [WORDS];
    bit                m_v   [WORDS];
    int                m_rr;
    logic [BITS:0]     exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_full();
        logic f;
        f = 1'b1;
        for (int i = 0; i < WORDS; i++) f = f & m_v[i];
        return f;
    endfunction

    task automatic model_flush();
        for (int i = 0; i < WORDS; i++) m_v[i] = 1'b0;
        m_rr = 0;
        exp_q.push_back({1'b0, {BITS{1'b0}}});
    endtask

    task automatic model_lookup(input logic [TAG_SZ-1:0] tag, input logic [BITS-1:0] mdata,
                                output logic hit, output int slot);
        hit  = 1'b0;
        slot = -1;
        for (int i = 0; i < WORDS; i++) begin
            if (m_v[i] && m_tag[i] == tag) begin
                hit  = 1'b1;
                slot = i;
            end
        end
        if (hit) begin
            exp_q.push_back({1'b1, m_dat[slot]});
        end else begin
            for (int i = WORDS - 1; i >= 0; i--) if (!m_v[i]) slot = i;
            if (slot < 0) begin
                slot = m_rr;
                m_rr = (m_rr + 1) % WORDS;
            end
            m_v[slot]   = 1'b1;
            m_tag[slot] = tag;
            m_dat[slot] = mdata;
            exp_q.push_back({1'b0, mdata});
        end
    endtask

    // One full transaction: issue, serve memory, watch CAM writes, check response.
    task automatic do_req(input logic flush, input logic [TAG_SZ-1:0] tag, input logic [BITS-1:0] mdata,
                          input int ack_dly, input int hold, output int wr_addr);
        logic          exp_hit;
        int            exp_slot;
        logic [BITS:0] exp_r;
        int            cyc, resp_cyc, ack_cyc, n_wr, n_mreq;
        logic          acked;

        exp_hit  = 1'b0;
        exp_slot = -1;
        if (flush) model_flush();
        else       model_lookup(tag, mdata, exp_hit, exp_slot);
        exp_r = exp_q.pop_front();

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_flush = flush;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_flush = 1'b0;

        cyc = 0; resp_cyc = -1; ack_cyc = -1; n_wr = 0; n_mreq = 0; acked = 1'b0; wr_addr = -1;
        while (resp_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (cyc == 1 && !flush) begin
                chk("cam_read", cam_read, 1);
                chk("cam_check_tag", cam_check_tag, tag);
            end
            if (mem_req) begin
                n_mreq++;
                if (n_mreq == 1) chk("mem_tag", mem_tag, tag);
                if (!acked && n_mreq > ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mdata;
                    acked     = 1'b1;
                    ack_cyc   = cyc;
                end
            end
            if (!cam_write_) begin
                n_wr++;
                wr_addr = cam_w_addr;
                if (flush) begin
                    chk("flush_addr", cam_w_addr, n_wr - 1);
                    chk("flush_cycle", cyc, n_wr);
                    chk("flush_fields", {cam_new_valid, cam_new_tag, cam_wdata}, 0);
                end else begin
                    chk("fill_addr", cam_w_addr, exp_slot);
                    chk("fill_cycle", cyc, ack_cyc + 1);
                    chk("fill_fields", {cam_new_valid, cam_new_tag, cam_wdata}, {1'b1, tag, mdata});
                end
            end
            if (resp_valid) resp_cyc = cyc;
        end
        mem_ack = 1'b0;
        chk("resp_seen", resp_cyc >= 0, 1);
        if (flush)        chk("flush_latency", resp_cyc, WORDS + 1);
        else if (exp_hit) chk("hit_latency", resp_cyc, 2);
        else              chk("miss_latency", resp_cyc, ack_cyc + 2);
        chk("write_count", n_wr, flush ? WORDS : (exp_hit ? 0 : 1));
        chk("mem_req_used", n_mreq > 0, !flush && !exp_hit);
        chk("resp_hit_data", {resp_hit, resp_data}, exp_r);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", {resp_hit, resp_data}, exp_r);
            chk("hold_req_ready", req_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_dropped", resp_valid, 0);
        chk("full", full, model_full());
    endtask

    task automatic reset_in_mem();
        int n, nwr;
        @(negedge clk);
        req_valid = 1'b1;
        req_flush = 1'b0;
        req_tag   = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mem_req_seen", mem_req, 1);
        chk("rst_mem_tag", mem_tag, 8'h77);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mem_req_drop", mem_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        nwr = 0;
        repeat (4) begin
            if (!cam_write_) nwr++;
            @(negedge clk);
        end
        chk("late_ack_no_write", nwr, 0);
        chk("late_ack_idle", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst_ = 1'b0; req_valid = 1'b0; req_flush = 1'b0; req_tag = '0;
        resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_dat[i] = '0;
        end
        m_rr = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {resp_valid, mem_req, cam_write_, cam_read, full, req_ready}, 6'b001001);
        rst_ = 1'b1;

        reset_in_mem();

        do_req(1'b0, 8'h11, 8'hA5, 1, 0, a);
        chk("t1_slot0", a, 0);
        do_req(1'b0, 8'h11, 8'h00, 0, 0, a);
        do_req(1'b1, 8'h00, 8'h00, 0, 0, a);

        for (int i = 0; i < WORDS; i++) begin
            do_req(1'b0, 8'h20 + 8'(i), 8'($urandom), $urandom_range(0, 3), 0, a);
            chk("t3_fill_order", a, i);
        end
        chk("t3_full", full, 1);
        for (int i = 0; i < 10; i++) begin
            do_req(1'b0, 8'h30 + 8'(i), 8'($urandom), $urandom_range(0, 3), 0, a);
            chk("t3_rr_slot", a, i % WORDS);
        end

        do_req(1'b1, 8'h00, 8'h00, 0, 0, a);
        chk("t4_full_clear", full, 0);
        do_req(1'b0, 8'h20, 8'h5C, 2, 0, a);
        chk("t4_after_flush_slot", a, 0);

        do_req(1'b0, 8'h44, 8'h3B, 0, 5, a);
        do_req(1'b0, 8'h44, 8'h00, 0, 5, a);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0)
                do_req(1'b1, 8'h00, 8'h00, 0, $urandom_range(0, 3), a);
            else
                do_req(1'b0, 8'h40 + 8'($urandom_range(0, 11)), 8'($urandom),
                       $urandom_range(0, 4), $urandom_range(0, 3), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
